// File: rtl/spi_fifo_pkg.sv
// Shared constants and the status record for the SPI master push/pop FIFO.
// The status fields are only used when SPI_FIFO_STATUS_EN is defined.
package spi_fifo_pkg;

    localparam int DROP_CNT_W = 16;
    // Wide enough for a fill level of up to 1024 entries.
    localparam int HWM_W      = 11;

    typedef struct packed {
        logic                  overflow;
        logic [DROP_CNT_W-1:0] drop_cnt;
        logic [HWM_W-1:0]      hwm;
    } spi_fifo_status_t;

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/spi_fifo_mem.sv
// FIFO storage: one write port and one asynchronous read port.
// The array has no reset, so contents persist across flushes and resets.
module spi_fifo_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int AW         = 3
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/spi_master_fifo_flow.sv
// Valid/ready FIFO between the SPI master and its client.
// Build option SPI_FIFO_STATUS_EN adds overflow, drop-count and high-water-mark statistics.
module spi_master_fifo_flow
    import spi_fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int BUFFER_DEPTH = 8,
    parameter int AF_LEVEL     = BUFFER_DEPTH - 1,
    parameter int AE_LEVEL     = 1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              clr_i,
    input  logic                              valid_i,
    input  logic [DATA_WIDTH-1:0]             data_i,
    output logic                              ready_o,
    output logic                              valid_o,
    output logic [DATA_WIDTH-1:0]             data_o,
    input  logic                              ready_i,
    output logic [$clog2(BUFFER_DEPTH+1)-1:0] elements_o,
    output logic                              almost_full_o,
    output logic                              almost_empty_o,
    output logic                              overflow_o,
    output logic [DROP_CNT_W-1:0]             drop_cnt_o,
    output logic [$clog2(BUFFER_DEPTH+1)-1:0] hwm_o,
    input  logic                              stat_clr_i
);

    localparam int CW = $clog2(BUFFER_DEPTH + 1);
    localparam int AW = $clog2(BUFFER_DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop, drop;

    // Reset-cycle values are forced so the handshake looks empty while rst_i is high.
    assign ready_o        = rst_i | (count_q != CW'(BUFFER_DEPTH));
    assign valid_o        = ~rst_i & (count_q != '0);
    assign almost_full_o  = rst_i ? (AF_LEVEL == 0) : (count_q >= CW'(AF_LEVEL));
    assign almost_empty_o = rst_i | (count_q <= CW'(AE_LEVEL));
    assign elements_o     = count_q;

    assign push = valid_i & ready_o & ~rst_i;
    assign pop  = valid_o & ready_i;
    assign drop = valid_i & ~ready_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Explicit wrap compare keeps non-power-of-two depths correct.
            if (push) wr_ptr_d = (wr_ptr_q == AW'(BUFFER_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = (rd_ptr_q == AW'(BUFFER_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    spi_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUFFER_DEPTH),
        .AW         (AW)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (push & ~clr_i),
        .waddr_i (wr_ptr_q),
        .wdata_i (data_i),
        .raddr_i (rd_ptr_q),
        .rdata_o (data_o)
    );

`ifdef SPI_FIFO_STATUS_EN
    spi_fifo_status_t stat_q, stat_d;
    logic             unused_hwm_bits;

    always_comb begin
        stat_d = stat_q;
        if (stat_clr_i) begin
            stat_d = '0;
        end else begin
            if (drop) begin
                stat_d.overflow = 1'b1;
                stat_d.drop_cnt = sat_inc(stat_q.drop_cnt);
            end
            if (HWM_W'(count_d) > stat_q.hwm) stat_d.hwm = HWM_W'(count_d);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign overflow_o      = stat_q.overflow;
    assign drop_cnt_o      = stat_q.drop_cnt;
    assign hwm_o           = stat_q.hwm[CW-1:0];
    assign unused_hwm_bits = ^stat_q.hwm;
`else
    logic unused_stat;

    assign overflow_o  = 1'b0;
    assign drop_cnt_o  = '0;
    assign hwm_o       = '0;
    assign unused_stat = stat_clr_i ^ drop;
`endif

endmodule

// File: tb/tb_spi_master_fifo_flow.sv
// Two FIFOs (depth 8 and depth 5) driven by identical stimulus, each checked every cycle
// against a queue-based reference model; status expectations follow SPI_FIFO_STATUS_EN.
module tb_spi_master_fifo_flow;

    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, clr, valid, rdy, sclr;
    logic [DW-1:0] din;

    logic          a_ready, a_valid, a_af, a_ae, a_ovf;
    logic [DW-1:0] a_data;
    logic [3:0]    a_elem, a_hwm;
    logic [15:0]   a_drop;
    logic          b_ready, b_valid, b_af, b_ae, b_ovf;
    logic [DW-1:0] b_data;
    logic [2:0]    b_elem, b_hwm;
    logic [15:0]   b_drop;

    spi_master_fifo_flow #(.DATA_WIDTH(DW), .BUFFER_DEPTH(8)) dut_a (
        .clk_i(clk), .rst_i(rst), .clr_i(clr),
        .valid_i(valid), .data_i(din), .ready_o(a_ready),
        .valid_o(a_valid), .data_o(a_data), .ready_i(rdy),
        .elements_o(a_elem), .almost_full_o(a_af), .almost_empty_o(a_ae),
        .overflow_o(a_ovf), .drop_cnt_o(a_drop), .hwm_o(a_hwm), .stat_clr_i(sclr)
    );

    spi_master_fifo_flow #(.DATA_WIDTH(DW), .BUFFER_DEPTH(5)) dut_b (
        .clk_i(clk), .rst_i(rst), .clr_i(clr),
        .valid_i(valid), .data_i(din), .ready_o(b_ready),
        .valid_o(b_valid), .data_o(b_data), .ready_i(rdy),
        .elements_o(b_elem), .almost_full_o(b_af), .almost_empty_o(b_ae),
        .overflow_o(b_ovf), .drop_cnt_o(b_drop), .hwm_o(b_hwm), .stat_clr_i(sclr)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: one queue plus statistics per instance.
    logic [DW-1:0] mq [2][$];
    int            m_depth [2] = '{8, 5};
    int            m_af    [2] = '{7, 4};
    bit            m_ovf   [2];
    int            m_drop  [2];
    int            m_hwm   [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_dut(input int k, input logic v, input logic r, input logic af,
                           input logic ae, input logic ovf, input logic [DW-1:0] d,
                           input int elem, input int drop, input int hwm);
        int    n;
        string p;
        n = mq[k].size();
        p = (k == 0) ? "d8" : "d5";
        chk({p, "_valid"}, v, rst ? 1'b0 : (n != 0));
        chk({p, "_ready"}, r, rst ? 1'b1 : (n != m_depth[k]));
        chk({p, "_elem"}, elem, n);
        chk({p, "_ae"}, ae, rst ? 1'b1 : (n <= 1));
        chk({p, "_af"}, af, rst ? 1'b0 : (n >= m_af[k]));
        if (!rst && n != 0) chk({p, "_data"}, d, mq[k][0]);
`ifdef SPI_FIFO_STATUS_EN
        chk({p, "_ovf"}, ovf, m_ovf[k]);
        chk({p, "_drop"}, drop, m_drop[k]);
        chk({p, "_hwm"}, hwm, m_hwm[k]);
`else
        chk({p, "_ovf"}, ovf, 1'b0);
        chk({p, "_drop"}, drop, 0);
        chk({p, "_hwm"}, hwm, 0);
`endif
    endtask

    task automatic model_step(input int k);
        int n;
        bit push, pop, drop;
        n    = mq[k].size();
        push = valid && (n != m_depth[k]);
        pop  = rdy && (n != 0);
        drop = valid && (n == m_depth[k]);
        if (rst) begin
            mq[k].delete();
            m_ovf[k]  = 1'b0;
            m_drop[k] = 0;
            m_hwm[k]  = 0;
        end else begin
            if (clr) begin
                mq[k].delete();
            end else begin
                if (pop)  void'(mq[k].pop_front());
                if (push) mq[k].push_back(din);
            end
            if (sclr) begin
                m_ovf[k]  = 1'b0;
                m_drop[k] = 0;
                m_hwm[k]  = 0;
            end else begin
                if (drop) begin
                    m_ovf[k] = 1'b1;
                    if (m_drop[k] < 16'hFFFF) m_drop[k]++;
                end
                if (mq[k].size() > m_hwm[k]) m_hwm[k] = mq[k].size();
            end
        end
    endtask

    // One clock cycle: drive, check at the falling edge, advance the model at the rising edge.
    task automatic cyc(input logic v, input logic [DW-1:0] d, input logic r,
                       input logic c, input logic s, input logic rs);
        valid = v; din = d; rdy = r; clr = c; sclr = s; rst = rs;
        @(negedge clk);
        chk_dut(0, a_valid, a_ready, a_af, a_ae, a_ovf, a_data, a_elem, a_drop, a_hwm);
        chk_dut(1, b_valid, b_ready, b_af, b_ae, b_ovf, b_data, b_elem, b_drop, b_hwm);
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    initial begin
        logic [DW-1:0] rd;
        int            exp_stat;

        valid = 0; din = '0; rdy = 0; clr = 0; sclr = 0; rst = 1;
        for (int k = 0; k < 2; k++) begin
            m_ovf[k] = 1'b0; m_drop[k] = 0; m_hwm[k] = 0;
        end
        #1;
        cyc(0, '0, 0, 0, 0, 1);
        cyc(0, '0, 0, 0, 0, 1);

        // Fill with 1..8 while the consumer stalls, then drain in order.
        for (int i = 1; i <= 8; i++) cyc(1, DW'(i), 0, 0, 0, 0);
        #2;
        chk("fill_ready_low", a_ready, 1'b0);
        chk("fill_af", a_af, 1'b1);
        for (int i = 0; i < 9; i++) cyc(0, '0, 1, 0, 0, 0);
        #2;
        chk("drain_valid_low", a_valid, 1'b0);

        // Overflow: full FIFO, valid held three cycles.
        cyc(0, '0, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) cyc(1, DW'($urandom), 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 16'hDEAD, 0, 0, 0, 0);
        #2;
`ifdef SPI_FIFO_STATUS_EN
        exp_stat = 3;
`else
        exp_stat = 0;
`endif
        chk("ovf_drop_cnt", a_drop, exp_stat);
        chk("ovf_flag", a_ovf, exp_stat != 0);
        cyc(0, '0, 0, 0, 1, 0);
        #2;
        chk("statclr_drop", a_drop, 0);
        chk("statclr_hwm", a_hwm, 0);
        for (int i = 0; i < 8; i++) cyc(0, '0, 1, 0, 0, 0);

        // Flush with a simultaneous push and pop at four elements.
        cyc(0, '0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) cyc(1, DW'(16'h40 + i), 0, 0, 0, 0);
        cyc(1, 16'hBEEF, 1, 1, 0, 0);
        #2;
        chk("clr_elem", a_elem, 0);
        chk("clr_hwm", a_hwm, (exp_stat != 0) ? 4 : 0);
        cyc(0, '0, 0, 0, 0, 0);

        // Pointer wrap in the depth-5 FIFO: 12 push/pop pairs at three elements.
        for (int i = 0; i < 3; i++) cyc(1, DW'(16'h100 + i), 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) cyc(1, DW'(16'h200 + i), 1, 0, 0, 0);
        #2;
        chk("wrap_elem", b_elem, 3);
        rd = 16'h209;
        chk("wrap_head", b_data, rd);
        cyc(0, '0, 1, 1, 0, 0);

        // Reset beats flush while full.
        for (int i = 0; i < 8; i++) cyc(1, DW'($urandom), 0, 0, 0, 0);
        cyc(1, 16'h1234, 1, 1, 1, 1);
        #2;
        chk("rst_elem", a_elem, 0);
        chk("rst_valid", a_valid, 1'b0);
        chk("rst_ready", a_ready, 1'b1);
        chk("rst_drop", a_drop, 0);

        // Random traffic; flush only while no push is offered.
        for (int i = 0; i < 400; i++) begin
            logic v, c;
            v = ($urandom_range(0, 3) != 0);
            c = !v && ($urandom_range(0, 40) == 0);
            cyc(v, DW'($urandom), ($urandom_range(0, 2) == 0), c,
                ($urandom_range(0, 30) == 0), ($urandom_range(0, 150) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_master_fifo_flow.md
SPI_MASTER_FIFO_FLOW -- requirements
Module: spi_master_fifo_flow

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: bits per entry, legal range 1..64.
REQ-002 SHALL have parameter BUFFER_DEPTH, default 8: entries, legal range 2..1024; power of two not required.
REQ-003 SHALL have parameter AF_LEVEL, default BUFFER_DEPTH-1: almost_full_o asserts when elements >= AF_LEVEL.
REQ-004 SHALL have parameter AE_LEVEL, default 1: almost_empty_o asserts when elements <= AE_LEVEL.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port clr_i, input, 1 bit: synchronous flush.
REQ-008 SHALL have ports valid_i (in, 1), data_i (in, DATA_WIDTH) and ready_o (out, 1): the push side.
REQ-009 SHALL have ports valid_o (out, 1), data_o (out, DATA_WIDTH) and ready_i (in, 1): the pop side.
REQ-010 SHALL have port elements_o, output, clog2(BUFFER_DEPTH+1) bits: current fill level.
REQ-011 SHALL have ports almost_full_o and almost_empty_o, outputs, 1 bit each: threshold flags.
REQ-012 SHALL have port overflow_o, output, 1 bit: sticky flag, set when a push is dropped.
REQ-013 SHALL have port drop_cnt_o, output, 16 bits: saturating count of dropped pushes.
REQ-014 SHALL have port hwm_o, output, same width as elements_o: high-water mark.
REQ-015 SHALL have port stat_clr_i, input, 1 bit: clears overflow_o, drop_cnt_o and hwm_o.

Function
REQ-016 SHALL accept a push on any cycle with valid_i && ready_o, where ready_o = (elements != BUFFER_DEPTH).
REQ-017 SHALL complete a pop on any cycle with valid_o && ready_i, where valid_o = (elements != 0).
REQ-018 SHALL present data_o combinationally from the read pointer; a push in cycle N becomes visible on valid_o/data_o in cycle N+1.
REQ-019 SHALL keep elements unchanged on a simultaneous push and pop, including at depth 1 and at depth BUFFER_DEPTH-1.
REQ-020 SHALL reject a push when full, even if a pop occurs in the same cycle, because ready_o does not depend on ready_i.
REQ-021 SHALL wrap each pointer from BUFFER_DEPTH-1 to 0 by explicit compare, which also covers non-power-of-two depths.
REQ-022 SHALL, on a dropped push (valid_i && !ready_o), set overflow_o and increment drop_cnt_o, saturating at 0xFFFF.
REQ-023 SHALL update hwm_o to max(hwm_o, next elements) every cycle.
REQ-024 SHALL derive almost_full_o and almost_empty_o from the registered elements count only, with no lookahead.
REQ-025 SHALL, on clr_i, zero both pointers and elements next cycle, ignore any push or pop in that cycle, and leave statistics untouched.
REQ-026 SHALL, on stat_clr_i, zero the statistics next cycle; if a drop occurs in the same cycle, the clear wins.
REQ-027 SHALL treat valid_i with data_i held stable until accepted as the master's obligation; the FIFO does not check it.

Reset
REQ-028 SHALL, on rst_i high at a clock edge, set pointers, elements, overflow_o, drop_cnt_o and hwm_o to 0.
REQ-029 SHALL, in the reset cycle, drive valid_o=0, ready_o=1, almost_empty_o=1 and almost_full_o=(AF_LEVEL==0).
REQ-030 SHALL leave storage contents unreset; data_o is don't-care while valid_o=0.
REQ-031 SHALL give rst_i priority over clr_i and stat_clr_i; a reset mid-transfer discards all contents.

Configuration
REQ-032 SHALL compile overflow_o, drop_cnt_o, hwm_o and their registers in only when SPI_FIFO_STATUS_EN is defined.
REQ-033 SHALL, without SPI_FIFO_STATUS_EN, keep the status ports present but tie them to 0, ignore stat_clr_i, and leave all other behaviour identical.

Structure
REQ-034 SHALL take from package spi_fifo_pkg the constant DROP_CNT_W=16 and the typedef spi_fifo_status_t, a struct of overflow, drop_cnt and hwm.
REQ-035 SHALL implement storage in sub-module spi_fifo_mem: one write port, one asynchronous read port, no reset.
REQ-036 SHALL keep the pointer, count, flag and statistics logic in spi_master_fifo_flow.

Verification
REQ-037 SHALL cover fill/drain: DEPTH=8, push 0x1..0x8 with ready_i=0 -> ready_o=0 after 8th push, almost_full_o=1 at 7 elements; then ready_i=1 -> data_o reads 0x1..0x8 in order, valid_o=0 after the last.
REQ-038 SHALL cover non-power-of-two depth: DEPTH=5, 12 push/pop pairs at 3 elements -> pointers wrap 4->0, order preserved, elements stays at 3.
REQ-039 SHALL cover overflow: full FIFO, valid_i held 3 cycles with ready_i=0 -> overflow_o=1, drop_cnt_o=3, contents intact; stat_clr_i pulse -> all statistics 0.
REQ-040 SHALL cover simultaneous flush: clr_i asserted with valid_i=1 and ready_i=1 at 4 elements -> elements_o=0 next cycle, no data written, hwm_o still 4.
REQ-041 SHALL cover reset priority: rst_i and clr_i both high while full -> all counters and statistics 0, valid_o=0, ready_o=1 next cycle.
REQ-042 SHALL cover the macro-off build: compile without SPI_FIFO_STATUS_EN and repeat the REQ-039 stimulus -> status outputs stay 0 and data behaviour matches the macro-on build.
